// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display blocks: segment bit positions,
// all-dark output codes and the hex-digit glyph table.
package seg7_pkg;

  // Bit position of each segment inside the 8-bit segment bus.
  typedef enum logic [2:0] {
    SEG_A  = 3'd0,
    SEG_B  = 3'd1,
    SEG_C  = 3'd2,
    SEG_D  = 3'd3,
    SEG_E  = 3'd4,
    SEG_F  = 3'd5,
    SEG_G  = 3'd6,
    SEG_DP = 3'd7
  } seg_idx_e;

  // Active-low "everything dark" codes for segments and digit enables.
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] DIG_OFF = 4'hF;

  // Active-high glyphs, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] HEX7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    return HEX7_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment glyph (g..a).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex7(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Each digit owns a slot of SCAN_DIV cycles; the first BLANK_CYC cycles of a
// slot keep every digit dark so the previous digit's glyph cannot ghost onto
// the next one. The digit's value is snapshotted in the last dark cycle, so
// input changes during the drive phase only show up in the next slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 2500,
  parameter int BLANK_CYC = 8,
  parameter int CNT_W     = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] SEG_A_VAL,
  input  logic [3:0] SEG_B_VAL,
  input  logic [3:0] SEG_C_VAL,
  input  logic [3:0] SEG_D_VAL,
  input  logic [3:0] DP_IN,
  input  logic [3:0] BLANK_IN,
  output logic [7:0] SEG_N,
  output logic [3:0] DIG_N,
  output logic       FRAME_P
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SNAP  = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       val_q, val_d;
  logic             dp_q, dp_d;
  logic             off_q, off_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic [3:0]       dig_n_q, dig_n_d;
  logic             frame_p_q, frame_p_d;

  logic [3:0]       nib_sel;
  logic [6:0]       glyph;

  seg7_hex_decode u_dec (
    .nib (val_q),
    .seg (glyph)
  );

  // Pick the nibble belonging to the digit currently being scanned.
  always_comb begin
    nib_sel = SEG_A_VAL;
    case (idx_q)
      2'd0:    nib_sel = SEG_A_VAL;
      2'd1:    nib_sel = SEG_B_VAL;
      2'd2:    nib_sel = SEG_C_VAL;
      default: nib_sel = SEG_D_VAL;
    endcase
  end

  // Slot sequencing, end-of-blanking snapshot and registered pin values.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    val_d     = val_q;
    dp_d      = dp_q;
    off_d     = off_q;
    seg_n_d   = SEG_OFF;
    dig_n_d   = DIG_OFF;
    frame_p_d = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    if (cnt_q == CNT_SNAP) begin
      val_d = nib_sel;
      dp_d  = DP_IN[idx_q];
      off_d = BLANK_IN[idx_q];
    end

    // Digit enable is derived from idx alone, so at most one bit can be low.
    if (!(cnt_q < CNT_BLANK) && !off_q) begin
      dig_n_d = ~(4'b0001 << idx_q);
      seg_n_d = {~dp_q, ~glyph};
    end

    frame_p_d = (cnt_q == CNT_LAST) && (idx_q == 2'd3);
  end

  // State and output registers; reset darkens the display immediately.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      val_q     <= 4'd0;
      dp_q      <= 1'b0;
      off_q     <= 1'b1;
      seg_n_q   <= SEG_OFF;
      dig_n_q   <= DIG_OFF;
      frame_p_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      dp_q      <= dp_d;
      off_q     <= off_d;
      seg_n_q   <= seg_n_d;
      dig_n_q   <= dig_n_d;
      frame_p_q <= frame_p_d;
    end
  end

  assign SEG_N   = seg_n_q;
  assign DIG_N   = dig_n_q;
  assign FRAME_P = frame_p_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with short slots (8 cycles, 2 dark).
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int CW = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] A, B, C, D, DP, BL;
  logic [7:0] SEG_N;
  logic [3:0] DIG_N;
  logic       FRAME_P;

  always #5 CLK = ~CLK;

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .SEG_A_VAL(A), .SEG_B_VAL(B), .SEG_C_VAL(C), .SEG_D_VAL(D),
    .DP_IN(DP), .BLANK_IN(BL),
    .SEG_N(SEG_N), .DIG_N(DIG_N), .FRAME_P(FRAME_P)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: absolute position since reset plus per-slot snapshot.
  int         pos = 0;
  logic [3:0] m_val = 4'd0;
  logic       m_dp = 1'b0;
  logic       m_off = 1'b1;
  logic [7:0] e_seg;
  logic [3:0] e_dig;
  logic       e_frame;
  int         last_frame = -1;
  logic [3:0] prev_dig = 4'hF;
  logic [3:0] runs[$];

  typedef struct {
    logic [3:0] val;
    logic       dp;
    logic [7:0] seg;
  } dec_vec_t;
  dec_vec_t tab[16];

  function automatic logic [6:0] ref_hex(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then compare.
  task automatic step();
    logic [3:0] vals[4];
    int ph, dg;
    @(posedge CLK);
    cyc++;
    vals[0] = A; vals[1] = B; vals[2] = C; vals[3] = D;
    if (RST) begin
      pos = 0; m_val = 4'd0; m_dp = 1'b0; m_off = 1'b1;
      e_seg = 8'hFF; e_dig = 4'hF; e_frame = 1'b0;
      last_frame = -1;
    end else begin
      ph = pos % SD;
      dg = (pos / SD) % 4;
      if (ph < BC || m_off) begin
        e_seg = 8'hFF; e_dig = 4'hF;
      end else begin
        e_dig = ~(4'b0001 << dg);
        e_seg = {~m_dp, ~ref_hex(m_val)};
      end
      e_frame = ((pos % (4 * SD)) == (4 * SD - 1));
      if (ph == BC - 1) begin
        m_val = vals[dg]; m_dp = DP[dg]; m_off = BL[dg];
      end
      pos++;
    end
    #1;
    chk("seg_n", SEG_N, e_seg);
    chk("dig_n", {4'h0, DIG_N}, {4'h0, e_dig});
    chk("frame_p", {7'h0, FRAME_P}, {7'h0, e_frame});
    chk("onehot", {7'h0, ($countones(~DIG_N) <= 1)}, 8'h01);
    if (FRAME_P) begin
      if (last_frame >= 0) chk("frame_period", 8'(cyc - last_frame), 8'd32);
      last_frame = cyc;
    end
    if (DIG_N != 4'hF && prev_dig == 4'hF) runs.push_back(DIG_N);
    prev_dig = DIG_N;
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!FRAME_P && n < 40);
    chk("frame_wait", {7'h0, FRAME_P}, 8'h01);
  endtask

  // Release reset and check the first-slot timing with A=1, B=2 loaded.
  task automatic release_check(input string tag);
    logic [7:0] sg[12];
    logic [3:0] dg[12];
    RST = 1'b0;
    for (int i = 1; i < 12; i++) begin
      step();
      sg[i] = SEG_N; dg[i] = DIG_N;
    end
    chk({tag, "_c2_dark"}, {4'h0, dg[2]}, 8'h0F);
    chk({tag, "_c3_dig"},  {4'h0, dg[3]}, 8'h0E);
    chk({tag, "_c3_seg"},  sg[3], 8'hF9);
    chk({tag, "_c8_dig"},  {4'h0, dg[8]}, 8'h0E);
    chk({tag, "_c9_dark"}, {4'h0, dg[9]}, 8'h0F);
    chk({tag, "_c10_dark"}, {4'h0, dg[10]}, 8'h0F);
    chk({tag, "_c11_dig"}, {4'h0, dg[11]}, 8'h0D);
    chk({tag, "_c11_seg"}, sg[11], 8'hA4);
  endtask

  initial begin
    logic [7:0] sg[32];
    logic [3:0] dg[32];
    int lit3;

    tab[0]  = '{4'h0, 1'b0, 8'hC0}; tab[1]  = '{4'h1, 1'b0, 8'hF9};
    tab[2]  = '{4'h2, 1'b0, 8'hA4}; tab[3]  = '{4'h3, 1'b1, 8'h30};
    tab[4]  = '{4'h4, 1'b0, 8'h99}; tab[5]  = '{4'h5, 1'b0, 8'h92};
    tab[6]  = '{4'h6, 1'b0, 8'h82}; tab[7]  = '{4'h7, 1'b0, 8'hF8};
    tab[8]  = '{4'h8, 1'b1, 8'h00}; tab[9]  = '{4'h9, 1'b0, 8'h90};
    tab[10] = '{4'hA, 1'b0, 8'h88}; tab[11] = '{4'hB, 1'b0, 8'h83};
    tab[12] = '{4'hC, 1'b0, 8'hC6}; tab[13] = '{4'hD, 1'b0, 8'hA1};
    tab[14] = '{4'hE, 1'b0, 8'h86}; tab[15] = '{4'hF, 1'b0, 8'h8E};

    // Reset and first-slot timing.
    RST = 1'b1; A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4; DP = 4'h0; BL = 4'h0;
    repeat (3) step();
    chk("rst_seg", SEG_N, 8'hFF);
    chk("rst_dig", {4'h0, DIG_N}, 8'h0F);
    runs.delete();
    release_check("rel1");

    // Scan order over more than two frames.
    repeat (60) step();
    chk("runs_count", {7'h0, (runs.size() >= 5)}, 8'h01);
    if (runs.size() >= 5) begin
      chk("run0", {4'h0, runs[0]}, 8'h0E);
      chk("run1", {4'h0, runs[1]}, 8'h0D);
      chk("run2", {4'h0, runs[2]}, 8'h0B);
      chk("run3", {4'h0, runs[3]}, 8'h07);
      chk("run4", {4'h0, runs[4]}, 8'h0E);
    end

    // Decode sweep, one value per frame on digit 0.
    for (int i = 0; i < 16; i++) begin
      wait_frame();
      A = tab[i].val;
      DP = {3'b000, tab[i].dp};
      repeat (3) step();
      chk($sformatf("dec_%0h_dig", tab[i].val), {4'h0, DIG_N}, 8'h0E);
      chk($sformatf("dec_%0h_seg", tab[i].val), SEG_N, tab[i].seg);
    end

    // Decimal point on digit 1, digit 3 forced dark.
    A = 4'h0; B = 4'h2; C = 4'h8; D = 4'h4; DP = 4'b0010; BL = 4'b1000;
    wait_frame();
    wait_frame();
    lit3 = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      sg[k] = SEG_N; dg[k] = DIG_N;
      if (k >= 24 && DIG_N != 4'hF) lit3++;
    end
    chk("dp_d1_dig", {4'h0, dg[10]}, 8'h0D);
    chk("dp_d1_seg", sg[10], 8'h24);
    chk("d2_dig", {4'h0, dg[18]}, 8'h0B);
    chk("d2_seg", sg[18], 8'h80);
    chk("blank_d3", 8'(lit3), 8'd0);

    // Mid-drive change of A holds until the next slot.
    DP = 4'h0; BL = 4'h0; A = 4'h5;
    wait_frame();
    repeat (5) step();
    chk("hold_pre", SEG_N, 8'h92);
    A = 4'h9;
    for (int k = 5; k < 8; k++) begin
      step();
      chk("hold_mid", SEG_N, 8'h92);
    end
    wait_frame();
    repeat (3) step();
    chk("hold_next", SEG_N, 8'h90);

    // One-cycle reset during digit 2 drive.
    A = 4'h1; B = 4'h2; C = 4'h3; D = 4'h4;
    wait_frame();
    repeat (20) step();
    chk("pre_rst_dig", {4'h0, DIG_N}, 8'h0B);
    RST = 1'b1;
    step();
    chk("midrst_seg", SEG_N, 8'hFF);
    chk("midrst_dig", {4'h0, DIG_N}, 8'h0F);
    chk("midrst_frame", {7'h0, FRAME_P}, 8'h00);
    release_check("rel2");

    // Randomized inputs with occasional resets against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        DP = 4'($urandom); BL = 4'($urandom);
      end
      RST = ($urandom_range(0, 149) == 0);
      step();
    end
    RST = 1'b0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
